// File: rtl/pcie_link_channel.sv
// pcie_link_channel
// -----------------
// Multi-lane link channel model. Each lane carries an 11-bit entry
// {idle, symbol[9:0]} through a fixed-depth delay line. The lane tap is chosen
// by a per-lane skew that is captured only while the channel is disabled. The
// tapped entry is registered, then polarity inversion and lane reversal are
// applied combinationally on the way out. A single-shot error injector can XOR
// a mask into one lane's incoming symbol. It then tracks that entry until the
// entry appears on the output.
//
// Ports
//   Clk            in   clock, all state on rising edge
//   notReset       in   asynchronous active-low reset
//   Enable         in   channel active; low flushes lines and relatches skews
//   LinkIn         in   LANES x 10-bit symbols, lane n at [n*10+9:n*10]
//   ElecIdleIn     in   per-lane electrical idle
//   LaneSkew       in   LANES x 4-bit extra delay request
//   InvertPolarity in   per-lane output symbol inversion (non-idle only)
//   LaneReverse    in   output lane m sourced from delay line LANES-1-m
//   ErrInjStb      in   single-cycle injection request
//   ErrInjLane     in   input lane to corrupt
//   ErrInjMask     in   XOR mask for the corrupted symbol
//   LinkOut        out  delayed symbols (0 on idle lanes)
//   ElecIdleOut    out  delayed electrical idle
//   ErrInjBusy     out  injection in flight
//   ErrInjDone     out  one-cycle pulse while the corrupted entry is on LinkOut
//   ErrInjCount    out  saturating count of completed injections

module pcie_link_channel #(
  parameter int LANES      = 16,
  parameter int BASE_DELAY = 1,
  parameter int MAX_SKEW   = 7
) (
  input  logic                 Clk,
  input  logic                 notReset,
  input  logic                 Enable,
  input  logic [LANES*10-1:0]  LinkIn,
  input  logic [LANES-1:0]     ElecIdleIn,
  input  logic [LANES*4-1:0]   LaneSkew,
  input  logic [LANES-1:0]     InvertPolarity,
  input  logic                 LaneReverse,
  input  logic                 ErrInjStb,
  input  logic [3:0]           ErrInjLane,
  input  logic [9:0]           ErrInjMask,
  output logic [LANES*10-1:0]  LinkOut,
  output logic [LANES-1:0]     ElecIdleOut,
  output logic                 ErrInjBusy,
  output logic                 ErrInjDone,
  output logic [15:0]          ErrInjCount
);

  localparam int          DEPTH      = BASE_DELAY + MAX_SKEW;
  localparam logic [10:0] IDLE_ENTRY = 11'h400;
  localparam logic [3:0]  MAX_SKEW_V = 4'(MAX_SKEW);
  localparam logic [4:0]  BASE_V     = 5'(BASE_DELAY);

  logic [10:0] line_q     [LANES][DEPTH];
  logic [10:0] emerge_q   [LANES];
  logic [3:0]  skew_q     [LANES];
  logic        busy_q;
  logic        done_q;
  logic [15:0] count_q;
  logic [4:0]  cnt_q;

  logic [10:0] entry_d      [LANES];
  logic [10:0] tap_entry_d  [LANES];
  logic [3:0]  skew_clamp_d [LANES];
  logic [3:0]  inj_skew_d;
  logic        inj_accept_d;

  // Injection acceptance: idle injector, active channel, lane that exists.
  always_comb begin
    inj_accept_d = ErrInjStb && !busy_q && Enable &&
                   ({28'd0, ErrInjLane} < 32'(LANES));
  end

  // Build the entry entering each delay line, with the mask XORed into the
  // target lane. An idle entry is still masked: the idle bit hides it later.
  always_comb begin
    for (int n = 0; n < LANES; n++) begin
      if (inj_accept_d && (ErrInjLane == 4'(n))) begin
        entry_d[n] = {ElecIdleIn[n], LinkIn[n*10 +: 10] ^ ErrInjMask};
      end else begin
        entry_d[n] = {ElecIdleIn[n], LinkIn[n*10 +: 10]};
      end
    end
  end

  // Clamp requested skews to the supported range.
  always_comb begin
    for (int n = 0; n < LANES; n++) begin
      if (LaneSkew[n*4 +: 4] > MAX_SKEW_V) begin
        skew_clamp_d[n] = MAX_SKEW_V;
      end else begin
        skew_clamp_d[n] = LaneSkew[n*4 +: 4];
      end
    end
  end

  // Pick stage BASE_DELAY+skew-1. The emerge register adds the final cycle,
  // so the total latency is BASE_DELAY+skew.
  always_comb begin
    for (int n = 0; n < LANES; n++) begin
      tap_entry_d[n] = IDLE_ENTRY;
      for (int d = 0; d < DEPTH; d++) begin
        if ((BASE_V + {1'b0, skew_q[n]}) == 5'(d + 1)) begin
          tap_entry_d[n] = line_q[n][d];
        end else begin
          tap_entry_d[n] = tap_entry_d[n];
        end
      end
    end
  end

  // Skew of the injection target lane, used to seed the countdown.
  always_comb begin
    inj_skew_d = 4'd0;
    for (int n = 0; n < LANES; n++) begin
      if (ErrInjLane == 4'(n)) begin
        inj_skew_d = skew_q[n];
      end else begin
        inj_skew_d = inj_skew_d;
      end
    end
  end

  // Delay lines and the registered emerging entry; flushed to idle when disabled.
  always_ff @(posedge Clk or negedge notReset) begin
    if (!notReset) begin
      for (int n = 0; n < LANES; n++) begin
        for (int d = 0; d < DEPTH; d++) begin
          line_q[n][d] <= IDLE_ENTRY;
        end
        emerge_q[n] <= IDLE_ENTRY;
      end
    end else if (!Enable) begin
      for (int n = 0; n < LANES; n++) begin
        for (int d = 0; d < DEPTH; d++) begin
          line_q[n][d] <= IDLE_ENTRY;
        end
        emerge_q[n] <= IDLE_ENTRY;
      end
    end else begin
      for (int n = 0; n < LANES; n++) begin
        line_q[n][0] <= entry_d[n];
        for (int d = 1; d < DEPTH; d++) begin
          line_q[n][d] <= line_q[n][d-1];
        end
        emerge_q[n] <= tap_entry_d[n];
      end
    end
  end

  // Skew registers follow LaneSkew while disabled and hold while enabled.
  always_ff @(posedge Clk or negedge notReset) begin
    if (!notReset) begin
      for (int n = 0; n < LANES; n++) begin
        skew_q[n] <= 4'd0;
      end
    end else if (!Enable) begin
      for (int n = 0; n < LANES; n++) begin
        skew_q[n] <= skew_clamp_d[n];
      end
    end else begin
      for (int n = 0; n < LANES; n++) begin
        skew_q[n] <= skew_q[n];
      end
    end
  end

  // Injection tracker. The countdown is loaded with latency-1. Done fires on
  // the edge that moves the corrupted entry into the emerge register.
  always_ff @(posedge Clk or negedge notReset) begin
    if (!notReset) begin
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= 5'd0;
      count_q <= 16'd0;
    end else if (!Enable) begin
      // Disabling abandons any injection in flight without completing it.
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= 5'd0;
    end else if (busy_q) begin
      if (cnt_q == 5'd0) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
        if (count_q != 16'hFFFF) begin
          count_q <= count_q + 16'd1;
        end else begin
          count_q <= count_q;
        end
      end else begin
        cnt_q  <= cnt_q - 5'd1;
        done_q <= 1'b0;
      end
    end else if (inj_accept_d) begin
      busy_q <= 1'b1;
      done_q <= 1'b0;
      cnt_q  <= BASE_V + {1'b0, inj_skew_d} - 5'd1;
    end else begin
      done_q <= 1'b0;
    end
  end

  // Output mapping: reversal picks the source line, and polarity follows the
  // source lane. Idle entries always drive a zero symbol.
  for (genvar m = 0; m < LANES; m++) begin : g_out
    logic [10:0] out_entry_s;
    logic        out_inv_s;
    assign out_entry_s = LaneReverse ? emerge_q[LANES-1-m] : emerge_q[m];
    assign out_inv_s   = LaneReverse ? InvertPolarity[LANES-1-m] : InvertPolarity[m];
    assign LinkOut[m*10 +: 10] = out_entry_s[10] ? 10'h000 :
                                 (out_inv_s ? ~out_entry_s[9:0] : out_entry_s[9:0]);
    assign ElecIdleOut[m] = out_entry_s[10];
  end

  assign ErrInjBusy  = busy_q;
  assign ErrInjDone  = done_q;
  assign ErrInjCount = count_q;

endmodule

// File: doc/pcie_link_channel.md
PCIE_LINK_CHANNEL -- requirements
Module: pcie_link_channel

Interface
REQ-001 SHALL have parameter LANES, default 16, number of physical lanes (1..16).
REQ-002 SHALL have parameter BASE_DELAY, default 1, fixed per-lane latency in Clk cycles (1..8).
REQ-003 SHALL have parameter MAX_SKEW, default 7, maximum extra per-lane delay in cycles (0..15).
REQ-004 SHALL have port Clk, input, 1, single clock; all state updates on rising edge.
REQ-005 SHALL have port notReset, input, 1, reset; asynchronous and active-low.
REQ-006 SHALL have port Enable, input, 1, channel active; low forces idle and allows reconfiguration.
REQ-007 SHALL have port LinkIn, input, LANES*10, 10-bit symbol per lane, lane n at [n*10+9:n*10].
REQ-008 SHALL have port ElecIdleIn, input, LANES, per-lane electrical idle.
REQ-009 SHALL have port LaneSkew, input, LANES*4, per-lane extra delay request.
REQ-010 SHALL have port InvertPolarity, input, LANES, per-lane symbol inversion.
REQ-011 SHALL have port LaneReverse, input, 1, swap lane n with lane LANES-1-n.
REQ-012 SHALL have port ErrInjStb, input, 1, single-cycle error injection request.
REQ-013 SHALL have port ErrInjLane, input, 4, target input lane for injection.
REQ-014 SHALL have port ErrInjMask, input, 10, XOR mask applied to injected symbol.
REQ-015 SHALL have port LinkOut, output, LANES*10, delayed symbols.
REQ-016 SHALL have port ElecIdleOut, output, LANES, delayed electrical idle.
REQ-017 SHALL have port ErrInjBusy, output, 1, injection pending/in flight.
REQ-018 SHALL have port ErrInjDone, output, 1, one-cycle pulse as corrupted symbol leaves LinkOut.
REQ-019 SHALL have port ErrInjCount, output, 16, saturating count of completed injections.

Function
REQ-020 SHALL carry per lane an 11-bit entry {idle, symbol} through a delay line of depth BASE_DELAY+MAX_SKEW.
REQ-021 SHALL latch LaneSkew into per-lane skew registers on every cycle Enable is low; high Enable freezes them.
REQ-022 SHALL clamp each latched skew to MAX_SKEW (e.g. request 12 with MAX_SKEW 7 -> 7).
REQ-023 SHALL present a lane input sampled at edge k on LinkOut/ElecIdleOut after edge k+BASE_DELAY+skew of that lane.
REQ-024 SHALL drive LinkOut lane symbol to 10'h000 whenever that lane's emerging entry has idle set.
REQ-025 SHALL apply InvertPolarity (bitwise NOT of symbol) at output only when the entry is not idle; idle bit never inverted.
REQ-026 SHALL, with LaneReverse high, map delay line n to output lane LANES-1-n for symbol and idle; applied combinationally at output, no added latency.
REQ-027 SHALL, while Enable is low, flush every delay-line stage to idle (11'h400) each cycle and drive LinkOut 0, ElecIdleOut all ones.
REQ-028 SHALL, on ErrInjStb with ErrInjBusy low and Enable high, XOR ErrInjMask into the symbol of lane ErrInjLane entering the delay line that same edge, and set ErrInjBusy.
REQ-029 SHALL ignore ErrInjStb when ErrInjBusy is high, Enable is low, or ErrInjLane >= LANES (no busy, no count).
REQ-030 SHALL inject even into an idle entry; the mask is then invisible on LinkOut but Done/Count still occur.
REQ-031 SHALL track the corrupted entry with a countdown of BASE_DELAY+skew; at emergence pulse ErrInjDone for one cycle, clear ErrInjBusy same edge, increment ErrInjCount.
REQ-032 SHALL saturate ErrInjCount at 16'hFFFF.
REQ-033 SHALL, if Enable drops while ErrInjBusy, clear ErrInjBusy without ErrInjDone or count increment.
REQ-034 SHALL accept a new ErrInjStb on the cycle after ErrInjDone.

Reset
REQ-035 SHALL, on notReset low, asynchronously clear: delay lines to idle, skew registers 0, ErrInjBusy 0, ErrInjDone 0, ErrInjCount 0; LinkOut 0, ElecIdleOut all ones.
REQ-036 SHALL, on reset mid-injection, abandon it without ErrInjDone; first cycle after release behaves as Enable-low if Enable is low.

Verification
REQ-037 SHALL test latency: LANES=4, BASE_DELAY=1, skews {0,1,2,3}, symbol 10'h17C on all lanes at edge 10 -> lane n output at edge 11+n.
REQ-038 SHALL test clamp/freeze: LaneSkew lane0=15, MAX_SKEW=7 -> delay 8; change LaneSkew with Enable high -> latency unchanged.
REQ-039 SHALL test polarity/reversal: InvertPolarity[0]=1, LaneReverse=1, lane0 in 10'h0F0 -> lane LANES-1 out 10'h30F; idle lanes out 0.
REQ-040 SHALL test injection: lane 2, mask 10'h001, symbol 10'h2AA, skew 3 -> 10'h2AB after 4 cycles, Done pulse, Count 1; second Stb while busy ignored.
REQ-041 SHALL test disruption: Enable low or notReset low mid-injection -> Busy 0, no Done, Count unchanged, outputs idle next edge (reset immediately).
